alu_cmd_driver: RTL

//   Initiator side of the pin-level ALU command interface. Accepts (op, a, b) requests on a

---
 rtl/alu_pin_pkg.sv | 46 ++++
 rtl/alu_ref_model.sv | 28 ++
 rtl/alu_cmd_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pin_pkg.sv
// Shared definitions for the pin-level ALU command interface: opcodes,
// field widths, driver FSM states and the pin pack/unpack helpers.
package alu_pin_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  localparam int OP_W  = 4;
  localparam int VAL_W = 6;
  localparam int RES_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [VAL_W-1:0] a;
    logic [VAL_W-1:0] b;
  } alu_cmd_t;

  // ui carries all of A plus the top two bits of B
  function automatic logic [7:0] pack_ui(input logic [VAL_W-1:0] a,
                                         input logic [VAL_W-1:0] b);
    return {b[5:4], a};
  endfunction

  // uio carries the opcode plus the low nibble of B
  function automatic logic [7:0] pack_uio(input logic [OP_W-1:0]  op,
                                          input logic [VAL_W-1:0] b);
    return {op, b[3:0]};
  endfunction

  // Recover the command fields from the two pin buses
  function automatic alu_cmd_t unpack_pins(input logic [7:0] ui,
                                           input logic [7:0] uio);
    alu_cmd_t c;
    c.op = uio[7:4];
    c.a  = ui[5:0];
    c.b  = {ui[7:6], uio[3:0]};
    return c;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference for the ALU macro: ADD/SUB on zero-extended
// 6-bit operands, modulo 256. Other opcodes yield 0 (not checked).
module alu_ref_model
  import alu_pin_pkg::*;
(
  input  logic [OP_W-1:0]  i_op,
  input  logic [VAL_W-1:0] i_a,
  input  logic [VAL_W-1:0] i_b,
  output logic [RES_W-1:0] o_expected
);

  logic [RES_W-1:0] w_a;
  logic [RES_W-1:0] w_b;

  assign w_a = {{(RES_W-VAL_W){1'b0}}, i_a};
  assign w_b = {{(RES_W-VAL_W){1'b0}}, i_b};

  // Select expected result by opcode
  always_comb begin
    o_expected = '0;
    case (i_op)
      OP_ADD:  o_expected = w_a + w_b;
      OP_SUB:  o_expected = w_a - w_b;
      default: o_expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the pin-level ALU: packs a request onto the ALU input
// pins, waits SETTLE_CYCLES, captures alu_uo and offers it as a response.
// Optional result checking is enabled with the ALU_CMD_CHECK_EN macro.
module alu_cmd_driver
  import alu_pin_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [VAL_W-1:0] req_a,
  input  logic [VAL_W-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_mismatch,
  output logic [7:0]       alu_ui,
  output logic [7:0]       alu_uio,
  input  logic [7:0]       alu_uo
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_ui;
  logic [7:0]       r_uio;
  logic             r_rsp_valid;
  logic [RES_W-1:0] r_rsp_data;
  logic             w_accept;
  logic             w_capture;
  logic             w_retire;

  assign w_accept  = (r_state == IDLE)   && req_valid;
  assign w_capture = (r_state == SETTLE) && (r_cnt == '0);
  assign w_retire  = (r_state == RESP)   && rsp_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid)      w_state_nxt = SETTLE;
      SETTLE:  if (r_cnt == '0)    w_state_nxt = RESP;
      RESP:    if (rsp_ready)      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  // Pin drive, settle countdown and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ui        <= '0;
      r_uio       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_ui  <= pack_ui(req_a, req_b);
        r_uio <= pack_uio(req_op, req_b);
        r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_data  <= alu_uo;
        r_rsp_valid <= 1'b1;
      end else if (w_retire) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_CMD_CHECK_EN
  alu_cmd_t         w_cmd;
  logic [RES_W-1:0] w_expected;
  logic             r_mismatch;

  // Latched command is recovered from the registered pins
  assign w_cmd = unpack_pins(r_ui, r_uio);

  alu_ref_model u_ref (
    .i_op       (w_cmd.op),
    .i_a        (w_cmd.a),
    .i_b        (w_cmd.b),
    .o_expected (w_expected)
  );

  // Compare captured result against the model; only ADD/SUB are judged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
    end else if (w_capture) begin
      r_mismatch <= ((w_cmd.op == OP_ADD) || (w_cmd.op == OP_SUB)) ?
                    (alu_uo != w_expected) : 1'b0;
    end else if (w_retire) begin
      r_mismatch <= 1'b0;
    end
  end

  assign rsp_mismatch = r_mismatch;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign alu_ui    = r_ui;
  assign alu_uio   = r_uio;

endmodule
